// File: rtl/ccu_slice_clkreq_sched.sv
// ccu_slice_clkreq_sched
//
// Sequences clock ungate/gate requests from several CCU clock slices onto the
// single command port of the shared clock generator. A slice is pending while
// its level request differs from its level ack. Pending slices are served
// round-robin, one command at a time. Each command waits for completion and
// then for a programmable settle gap, and the slice's ack follows the
// latched command.
//
// Ports:
//   clk         sole clock
//   rst         synchronous, active-high reset
//   clkreq      per-slice level request (1 = clock wanted, 0 = may gate)
//   clkack      per-slice level ack, updated once the slice's command completes
//   settle_dly  idle cycles inserted after each completion (sampled at completion)
//   cmd_valid   command offered to the clock generator
//   cmd_slice   target slice of the command
//   cmd_on      1 = ungate, 0 = gate
//   cmd_ready   generator accepts the command when cmd_valid & cmd_ready
//   cmd_done    one-cycle completion pulse, one per accepted command
//   busy        high whenever the scheduler is not idle
//   proto_err   sticky flag for a cmd_done outside the completion wait
module ccu_slice_clkreq_sched #(
    parameter int NUM_SLICES = 4,
    parameter int SEL_W      = $clog2(NUM_SLICES),
    parameter int DLY_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SLICES-1:0] clkreq,
    output logic [NUM_SLICES-1:0] clkack,
    input  logic [DLY_W-1:0]      settle_dly,
    output logic                  cmd_valid,
    output logic [SEL_W-1:0]      cmd_slice,
    output logic                  cmd_on,
    input  logic                  cmd_ready,
    input  logic                  cmd_done,
    output logic                  busy,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_SETTLE    = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [NUM_SLICES-1:0] clkack_r, clkack_nxt_s;
    logic [NUM_SLICES-1:0] pending_s;
    logic [SEL_W-1:0]      cmd_slice_r, cmd_slice_nxt_s;
    logic [SEL_W-1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic                  cmd_on_r, cmd_on_nxt_s;
    logic                  cmd_valid_r;
    logic                  busy_r;
    logic                  proto_err_r, proto_err_nxt_s;
    logic [DLY_W-1:0]      cnt_r, cnt_nxt_s;
    logic [SEL_W:0]        pick_s;

    // Round-robin pick: {found, index} of the first pending slice at or after ptr.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_SLICES-1:0] pend,
                                               input logic [SEL_W-1:0]      ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            idx = SEL_W'((int'(ptr) + k) % NUM_SLICES);
            if (pend[idx] && !res[SEL_W]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Slice index following idx, wrapping at NUM_SLICES.
    function automatic logic [SEL_W-1:0] next_slice(input logic [SEL_W-1:0] idx);
        if (idx == SEL_W'(NUM_SLICES - 1)) begin
            return '0;
        end else begin
            return idx + SEL_W'(1);
        end
    endfunction

    assign pending_s = clkreq ^ clkack_r;
    assign pick_s    = rr_pick(pending_s, rr_ptr_r);

    // Next-state, command latching, ack update and settle countdown.
    always_comb begin
        state_nxt_s     = state_r;
        clkack_nxt_s    = clkack_r;
        cmd_slice_nxt_s = cmd_slice_r;
        cmd_on_nxt_s    = cmd_on_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        cnt_nxt_s       = cnt_r;
        // Completion is only legal while waiting for it; acceptance happens in
        // ISSUE, so a done coincident with acceptance is also caught here.
        proto_err_nxt_s = proto_err_r | (cmd_done & (state_r != ST_WAIT_DONE));

        case (state_r)
            ST_IDLE: begin
                if (pick_s[SEL_W]) begin
                    state_nxt_s     = ST_ISSUE;
                    cmd_slice_nxt_s = pick_s[SEL_W-1:0];
                    cmd_on_nxt_s    = clkreq[pick_s[SEL_W-1:0]];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    // The ack takes the latched command, not the live request.
                    clkack_nxt_s[cmd_slice_r] = cmd_on_r;
                    rr_ptr_nxt_s              = next_slice(cmd_slice_r);
                    cnt_nxt_s                 = settle_dly;
                    if (settle_dly != '0) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_SETTLE: begin
                cnt_nxt_s = cnt_r - DLY_W'(1);
                if (cnt_r <= DLY_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; valid/busy are derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            clkack_r    <= '0;
            cmd_slice_r <= '0;
            cmd_on_r    <= 1'b0;
            rr_ptr_r    <= '0;
            cnt_r       <= '0;
            cmd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clkack_r    <= clkack_nxt_s;
            cmd_slice_r <= cmd_slice_nxt_s;
            cmd_on_r    <= cmd_on_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cmd_valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            proto_err_r <= proto_err_nxt_s;
        end
    end

    assign clkack    = clkack_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_slice = cmd_slice_r;
    assign cmd_on    = cmd_on_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_ccu_slice_clkreq_sched.sv
// Self-checking bench for ccu_slice_clkreq_sched (NUM_SLICES = 4).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the next rising edge.
module tb_ccu_slice_clkreq_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] clkreq;
    logic [3:0] clkack;
    logic [7:0] settle_dly;
    logic       cmd_valid;
    logic [1:0] cmd_slice;
    logic       cmd_on;
    logic       cmd_ready;
    logic       cmd_done;
    logic       busy;
    logic       proto_err;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       done;
        logic       valid;
        logic [1:0] sl;
        logic       on;
        logic [3:0] ack;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    ccu_slice_clkreq_sched #(
        .NUM_SLICES(4),
        .SEL_W(2),
        .DLY_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clkreq(clkreq),
        .clkack(clkack),
        .settle_dly(settle_dly),
        .cmd_valid(cmd_valid),
        .cmd_slice(cmd_slice),
        .cmd_on(cmd_on),
        .cmd_ready(cmd_ready),
        .cmd_done(cmd_done),
        .busy(busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] req, input logic rdy, input logic dn,
                       input logic v, input logic [1:0] sl, input logic on,
                       input logic [3:0] ack, input logic b, input logic e);
        vec_t t;
        t.rst = r; t.req = req; t.rdy = rdy; t.done = dn;
        t.valid = v; t.sl = sl; t.on = on; t.ack = ack; t.busy = b; t.err = e;
        tbl.push_back(t);
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, cmd_valid, cmd_slice, cmd_on, clkack, busy, proto_err};
    endfunction

    initial begin
        int k;
        int acc0;
        rst = 1'b1; clkreq = 4'b0000; settle_dly = 8'd0; cmd_ready = 1'b0; cmd_done = 1'b0;
        tick();

        // rst req rdy done | valid slice on ack busy err
        // single ungate, done one cycle after acceptance
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
        // round robin: all four rise together
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0001, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0001, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0011, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0011, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0011, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0111, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0111, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0111, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1111, 1'b0, 1'b0);
        // slices 0 and 2 drop: gate 0 (pointer wrapped to 0), then gate 2
        add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1111, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b0, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b1110, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b1110, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 4'b1010, 1'b0, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b1010, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; clkreq = tbl[i].req; cmd_ready = tbl[i].rdy; cmd_done = tbl[i].done;
            tick();
            chk($sformatf("vec%0d{valid,slice,on,ack,busy,err}", i), outs(),
                {22'd0, tbl[i].valid, tbl[i].sl, tbl[i].on, tbl[i].ack, tbl[i].busy, tbl[i].err});
        end
        cmd_done = 1'b0;

        // backpressure: ready low for 10 cycles, command held stable
        rst = 1'b1; clkreq = 4'b0000; cmd_ready = 1'b0; tick();
        rst = 1'b0; clkreq = 4'b0100; acc0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), {29'd0, cmd_valid, cmd_slice},
                {29'd0, 1'b1, 2'd2});
            chk($sformatf("bp_on%0d", i), {31'd0, cmd_on}, 32'd1);
        end
        cmd_ready = 1'b1; tick();
        chk("bp_valid_drop", {31'd0, cmd_valid}, 32'd0);
        cmd_ready = 1'b0; cmd_done = 1'b1; tick();
        cmd_done = 1'b0; tick(); tick();
        chk("bp_accept_count", acc_cnt - acc0, 32'd1);
        chk("bp_ack", {28'd0, clkack}, {28'd0, 4'b0100});

        // settle gap: N = 5, next valid 7 cycles after first done
        rst = 1'b1; clkreq = 4'b0000; tick();
        rst = 1'b0; clkreq = 4'b0011; settle_dly = 8'd5; cmd_ready = 1'b1;
        tick(); tick();
        cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("settle_ack", {28'd0, clkack}, {28'd0, 4'b0001});
        chk("settle_busy", {31'd0, busy}, 32'd1);
        k = 1;
        while (!cmd_valid && k < 20) begin
            tick();
            k++;
        end
        chk("settle_gap", k, 32'd7);
        chk("settle_next_slice", {30'd0, cmd_slice}, 32'd1);
        settle_dly = 8'd0;

        // withdrawal: slice 1 drops its request while in WAIT_DONE
        rst = 1'b1; clkreq = 4'b0000; tick();
        rst = 1'b0; clkreq = 4'b0010; cmd_ready = 1'b1;
        tick(); tick();
        clkreq = 4'b0000; tick();
        chk("wd_wait", {27'd0, cmd_valid, clkack}, {27'd0, 1'b0, 4'b0000});
        cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("wd_ack_up", {31'd0, clkack[1]}, 32'd1);
        tick();
        chk("wd_gate_cmd", {28'd0, cmd_valid, cmd_slice, cmd_on}, {28'd0, 1'b1, 2'd1, 1'b0});
        tick();
        cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("wd_ack_down", {28'd0, clkack}, {28'd0, 4'b0000});

        // spurious done in IDLE
        rst = 1'b1; tick();
        rst = 1'b0; cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("err_idle", {27'd0, proto_err, clkack}, {27'd0, 1'b1, 4'b0000});
        tick();
        chk("err_sticky", {26'd0, proto_err, busy, clkack}, {26'd0, 1'b1, 1'b0, 4'b0000});

        // done in the acceptance cycle: flagged, does not complete the command
        rst = 1'b1; tick();
        rst = 1'b0; clkreq = 4'b0001; cmd_ready = 1'b1; tick();
        cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("err_accept", {26'd0, proto_err, busy, clkack}, {26'd0, 1'b1, 1'b1, 4'b0000});
        tick();
        chk("err_accept_wait", {26'd0, busy, cmd_valid, clkack}, {26'd0, 1'b1, 1'b0, 4'b0000});
        cmd_done = 1'b1; tick();
        cmd_done = 1'b0;
        chk("err_accept_done", {27'd0, proto_err, clkack}, {27'd0, 1'b1, 4'b0001});

        // reset during WAIT_DONE
        clkreq = 4'b0011; tick(); tick();
        chk("rst_pre_wait", {29'd0, busy, cmd_slice}, {29'd0, 1'b1, 2'd1});
        rst = 1'b1; tick();
        chk("rst_mid", outs(), 32'd0);
        rst = 1'b0; clkreq = 4'b0000; cmd_ready = 1'b0; tick();
        chk("rst_after", outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
